// File: rtl/camera_ahb_pkg.sv
// Shared constants and helpers for the camera AHB-Lite arbiter.
// Holds the HTRANS/HBURST encodings, the master-count ceiling and a
// one-hot to index helper used by the arbiter top.
package camera_ahb_pkg;

  localparam int MAX_MST = 4;

  localparam logic [1:0] TRN_IDLE   = 2'b00;
  localparam logic [1:0] TRN_BUSY   = 2'b01;
  localparam logic [1:0] TRN_NONSEQ = 2'b10;
  localparam logic [1:0] TRN_SEQ    = 2'b11;

  localparam logic [2:0] BST_SINGLE = 3'b000;
  localparam logic [2:0] BST_INCR   = 3'b001;
  localparam logic [2:0] BST_INCR4  = 3'b011;

  // Burst classes the arbiter cares about; unknown HBURST codes fold into INCR.
  typedef enum logic [1:0] {
    BK_SINGLE = 2'd0,
    BK_INCR   = 2'd1,
    BK_INCR4  = 2'd2
  } burstKind_e;

  function automatic burstKind_e classifyBurst(input logic [2:0] hburst);
    burstKind_e kind;
    case (hburst)
      BST_SINGLE: kind = BK_SINGLE;
      BST_INCR4:  kind = BK_INCR4;
      BST_INCR:   kind = BK_INCR;
      default:    kind = BK_INCR;
    endcase
    return kind;
  endfunction

  function automatic logic [1:0] oneHotIdx(input logic [MAX_MST-1:0] vec);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_MST; i++) begin
      if (vec[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/camera_arb_pick.sv
// Combinational winner selection for the camera AHB arbiter.
// Build option CAMERA_ARB_RR_EN: round-robin starting after the last
// winner (ptr); otherwise fixed priority with the lowest index winning.
import camera_ahb_pkg::*;

module camera_arb_pick #(
  parameter int NUM_MST = 3
) (
  input  logic [NUM_MST-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_MST-1:0] winner,
  output logic [1:0]         winIdx
);

  logic found;

`ifdef CAMERA_ARB_RR_EN
  logic [MAX_MST-1:0] reqPad;
  logic [2:0]         startIdx;
  logic [2:0]         cand;

  assign reqPad   = MAX_MST'(req);
  assign startIdx = (ptr >= 2'(NUM_MST - 1)) ? 3'd0 : ({1'b0, ptr} + 3'd1);

  // Walk the masters once, starting just after the previous winner, wrapping at NUM_MST.
  always_comb begin
    winner = '0;
    winIdx = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      cand = startIdx + 3'(i);
      if (cand >= 3'(NUM_MST)) cand = cand - 3'(NUM_MST);
      if (!found && reqPad[cand[1:0]]) begin
        found               = 1'b1;
        winIdx              = cand[1:0];
        winner[cand[1:0]]   = 1'b1;
      end
    end
  end
`else
  logic unusedPtr;
  assign unusedPtr = ^ptr;

  // Lowest requesting index wins; the camera sits at index 0.
  always_comb begin
    winner = '0;
    winIdx = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (!found && req[i]) begin
        found     = 1'b1;
        winIdx    = 2'(i);
        winner[i] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/camera_ahb_arbiter.sv
// AHB-Lite arbiter for the camera subsystem (camera, CPU, optional DMA/eMMC).
// Re-arbitrates only at burst-safe points so INCR4 frame-store bursts stay whole;
// honours locked transfers. Build option CAMERA_ARB_RR_EN selects round-robin.
import camera_ahb_pkg::*;

module camera_ahb_arbiter #(
  parameter int NUM_MST = 3,
  parameter int DEF_MST = 0
) (
  input  logic               HCLK,
  input  logic               HReset_N,
  input  logic [NUM_MST-1:0] HBUSREQ,
  input  logic [NUM_MST-1:0] HLOCK,
  input  logic [1:0]         HTRANS,
  input  logic [2:0]         HBURST,
  input  logic               HREADY,
  output logic [NUM_MST-1:0] HGRANT,
  output logic [1:0]         HMASTER,
  output logic [1:0]         HMASTER_D,
  output logic               HMASTLOCK
);

  localparam logic [NUM_MST-1:0] DEF_GRANT = NUM_MST'(1 << DEF_MST);
  localparam logic [1:0]         DEF_IDX   = 2'(DEF_MST);

  logic [NUM_MST-1:0] r_Grant;
  logic [1:0]         r_HMASTER;
  logic [1:0]         r_HMASTER_D;
  logic [1:0]         r_BeatCnt;
  logic               r_Lock;
  logic [1:0]         r_Ptr;

  logic [MAX_MST-1:0] reqPad;
  logic [MAX_MST-1:0] lockPad;
  logic [MAX_MST-1:0] grantPad;
  logic [1:0]         grantIdx;
  logic               lockHold;
  logic               anyReq;
  logic               arbPoint;
  logic               arbOk;
  logic [NUM_MST-1:0] pickGrant;
  logic [1:0]         pickIdx;
  burstKind_e         burstKind;

  assign reqPad    = MAX_MST'(HBUSREQ);
  assign lockPad   = MAX_MST'(HLOCK);
  assign grantPad  = MAX_MST'(r_Grant);
  assign grantIdx  = oneHotIdx(grantPad);
  assign lockHold  = lockPad[r_HMASTER] & reqPad[r_HMASTER];
  assign anyReq    = |HBUSREQ;
  assign burstKind = classifyBurst(HBURST);

  // Decide whether the transfer on the bus is a point where ownership may change.
  always_comb begin
    arbPoint = 1'b0;
    if (HTRANS == TRN_IDLE) begin
      arbPoint = 1'b1;
    end else begin
      case (burstKind)
        BK_SINGLE: arbPoint = (HTRANS == TRN_NONSEQ);
        BK_INCR:   arbPoint = (HTRANS == TRN_NONSEQ) || (HTRANS == TRN_SEQ);
        BK_INCR4:  arbPoint = (HTRANS == TRN_SEQ) && (r_BeatCnt == 2'd2);
        default:   arbPoint = 1'b0;
      endcase
    end
  end

  assign arbOk = HREADY & arbPoint & ~lockHold;

  camera_arb_pick #(
    .NUM_MST (NUM_MST)
  ) uPick (
    .req    (HBUSREQ),
    .ptr    (r_Ptr),
    .winner (pickGrant),
    .winIdx (pickIdx)
  );

  // Track the beat position of the current burst; wait states freeze it.
  always_ff @(posedge HCLK or negedge HReset_N) begin
    if (!HReset_N) begin
      r_BeatCnt <= 2'd0;
    end else if (HREADY) begin
      case (HTRANS)
        TRN_IDLE:   r_BeatCnt <= 2'd0;
        TRN_BUSY:   r_BeatCnt <= r_BeatCnt;
        TRN_NONSEQ: r_BeatCnt <= 2'd1;
        TRN_SEQ:    if (r_BeatCnt != 2'd3) r_BeatCnt <= r_BeatCnt + 2'd1;
      endcase
    end
  end

  // Load a new grant at safe points; the pointer only matters in round-robin builds.
  always_ff @(posedge HCLK or negedge HReset_N) begin
    if (!HReset_N) begin
      r_Grant <= DEF_GRANT;
      r_Ptr   <= DEF_IDX;
    end else if (arbOk) begin
      if (anyReq) begin
        r_Grant <= pickGrant;
        r_Ptr   <= pickIdx;
      end else begin
        r_Grant <= DEF_GRANT;
      end
    end
  end

  // Advance address-phase and data-phase ownership on every completed transfer.
  always_ff @(posedge HCLK or negedge HReset_N) begin
    if (!HReset_N) begin
      r_HMASTER   <= DEF_IDX;
      r_HMASTER_D <= DEF_IDX;
      r_Lock      <= 1'b0;
    end else if (HREADY) begin
      r_HMASTER   <= grantIdx;
      r_HMASTER_D <= r_HMASTER;
      r_Lock      <= lockPad[grantIdx];
    end
  end

  assign HGRANT    = r_Grant;
  assign HMASTER   = r_HMASTER;
  assign HMASTER_D = r_HMASTER_D;
  assign HMASTLOCK = r_Lock;

endmodule

// File: tb/tb_camera_ahb_arbiter.sv
// Testbench for camera_ahb_arbiter: directed bus scenarios followed by random
// traffic, all checked against a behavioural model of the arbitration rules.
module tb_camera_ahb_arbiter;
  import camera_ahb_pkg::*;

  localparam int N   = 3;
  localparam int DEF = 0;

  logic         HCLK = 1'b0;
  logic         HReset_N;
  logic [N-1:0] HBUSREQ;
  logic [N-1:0] HLOCK;
  logic [1:0]   HTRANS;
  logic [2:0]   HBURST;
  logic         HREADY;
  logic [N-1:0] HGRANT;
  logic [1:0]   HMASTER;
  logic [1:0]   HMASTER_D;
  logic         HMASTLOCK;

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model state: who holds the grant, who owns each phase, and burst position.
  int mGrant;
  int mOwner;
  int mOwnerD;
  int mBeatNo;
  int mLast;
  bit mLocked;

  camera_ahb_arbiter #(
    .NUM_MST (N),
    .DEF_MST (DEF)
  ) dut (
    .HCLK      (HCLK),
    .HReset_N  (HReset_N),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HREADY    (HREADY),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTER_D (HMASTER_D),
    .HMASTLOCK (HMASTLOCK)
  );

  // Free-running bus clock.
  always #5 HCLK = ~HCLK;

  function automatic int pickWinner(input logic [N-1:0] req);
    int w;
    w = DEF;
`ifdef CAMERA_ARB_RR_EN
    for (int k = N; k >= 1; k--) begin
      if (req[(mLast + k) % N]) w = (mLast + k) % N;
    end
`else
    for (int c = N - 1; c >= 0; c--) begin
      if (req[c]) w = c;
    end
`endif
    return w;
  endfunction

  task automatic modelReset();
    mGrant  = DEF;
    mOwner  = DEF;
    mOwnerD = DEF;
    mBeatNo = 0;
    mLast   = DEF;
    mLocked = 1'b0;
  endtask

  task automatic modelEdge();
    bit arb;
    if (HReset_N !== 1'b1 || HREADY !== 1'b1) return;
    if (HTRANS == TRN_IDLE)        arb = 1'b1;
    else if (HTRANS == TRN_BUSY)   arb = 1'b0;
    else if (HTRANS == TRN_NONSEQ) arb = (HBURST != BST_INCR4);
    else                           arb = (HBURST == BST_INCR4) ? (mBeatNo == 2) : (HBURST != BST_SINGLE);
    if (HLOCK[mOwner] && HBUSREQ[mOwner]) arb = 1'b0;
    mOwnerD = mOwner;
    mOwner  = mGrant;
    mLocked = HLOCK[mGrant];
    if (arb) begin
      if (HBUSREQ == '0) begin
        mGrant = DEF;
      end else begin
        mGrant = pickWinner(HBUSREQ);
        mLast  = mGrant;
      end
    end
    if (HTRANS == TRN_IDLE)        mBeatNo = 0;
    else if (HTRANS == TRN_NONSEQ) mBeatNo = 1;
    else if (HTRANS == TRN_SEQ)    mBeatNo = mBeatNo + 1;
  endtask

  task automatic compare(input string tag, input logic [2:0] observed, input logic [2:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    compare({tag, ".HGRANT"},    HGRANT,            3'(1 << mGrant));
    compare({tag, ".HMASTER"},   {1'b0, HMASTER},   3'(mOwner));
    compare({tag, ".HMASTER_D"}, {1'b0, HMASTER_D}, 3'(mOwnerD));
    compare({tag, ".HMASTLOCK"}, {2'b0, HMASTLOCK}, {2'b0, mLocked});
  endtask

  // Drive one cycle of bus inputs, step the model across the edge and check just after it.
  task automatic applyStimulus(input logic [N-1:0] req, input logic [N-1:0] lock,
                               input logic [1:0] trans, input logic [2:0] burst,
                               input logic ready, input string tag);
    HBUSREQ = req;
    HLOCK   = lock;
    HTRANS  = trans;
    HBURST  = burst;
    HREADY  = ready;
    modelEdge();
    @(posedge HCLK);
    #1;
    checkOutput(tag);
  endtask

  task automatic pulseReset(input string tag);
    HReset_N = 1'b0;
    #2;
    modelReset();
    checkOutput(tag);
    #1;
    HReset_N = 1'b1;
  endtask

  logic [N-1:0] rrExp [4];
  logic [N-1:0] rReq;
  logic [N-1:0] rLock;
  logic [2:0]   rBurst;

  initial begin
    $display("[TB] camera_ahb_arbiter bench start");
    HReset_N = 1'b0;
    HBUSREQ  = '0;
    HLOCK    = '0;
    HTRANS   = TRN_IDLE;
    HBURST   = BST_SINGLE;
    HREADY   = 1'b1;
    modelReset();
    @(posedge HCLK);
    #1;
    checkOutput("reset");
    compare("reset.grantConst", HGRANT, 3'b001);
    @(posedge HCLK);
    #1;
    HReset_N = 1'b1;

    // Idle bus with no requests: default master parked.
    repeat (3) applyStimulus(3'b000, 3'b000, TRN_IDLE, BST_SINGLE, 1'b1, "s1.idle");
    compare("s1.grant", HGRANT, 3'b001);
    compare("s1.master", {1'b0, HMASTER}, 3'd0);
    compare("s1.masterD", {1'b0, HMASTER_D}, 3'd0);

    // Master 1 requests alone on an idle bus.
    applyStimulus(3'b010, 3'b000, TRN_IDLE, BST_SINGLE, 1'b1, "s2.req");
    compare("s2.grant", HGRANT, 3'b010);
    compare("s2.ownerBefore", {1'b0, HMASTER}, 3'd0);
    applyStimulus(3'b010, 3'b000, TRN_IDLE, BST_SINGLE, 1'b1, "s2.handover");
    compare("s2.owner", {1'b0, HMASTER}, 3'd1);
    applyStimulus(3'b000, 3'b000, TRN_NONSEQ, BST_SINGLE, 1'b1, "s2.nonseq");
    compare("s2.dataOwner", {1'b0, HMASTER_D}, 3'd1);
    compare("s2.grantBack", HGRANT, 3'b001);
    applyStimulus(3'b000, 3'b000, TRN_IDLE, BST_SINGLE, 1'b1, "s2.idle");

    // Master 0 INCR4 while master 2 waits: switch only after beat 3.
    applyStimulus(3'b100, 3'b000, TRN_NONSEQ, BST_INCR4, 1'b1, "s3.beat1");
    compare("s3.grantBeat1", HGRANT, 3'b001);
    applyStimulus(3'b100, 3'b000, TRN_SEQ, BST_INCR4, 1'b1, "s3.beat2");
    compare("s3.grantBeat2", HGRANT, 3'b001);
    applyStimulus(3'b100, 3'b000, TRN_SEQ, BST_INCR4, 1'b1, "s3.beat3");
    compare("s3.grantBeat3", HGRANT, 3'b100);
    compare("s3.ownerBeat4", {1'b0, HMASTER}, 3'd0);
    applyStimulus(3'b100, 3'b000, TRN_SEQ, BST_INCR4, 1'b1, "s3.beat4");
    compare("s3.ownerNext", {1'b0, HMASTER}, 3'd2);
    applyStimulus(3'b000, 3'b000, TRN_NONSEQ, BST_SINGLE, 1'b1, "s3.m2nonseq");
    compare("s3.dataOwner", {1'b0, HMASTER_D}, 3'd2);
    applyStimulus(3'b000, 3'b000, TRN_IDLE, BST_SINGLE, 1'b1, "s3.idle");

    // INCR4 with two wait states on beat 3 while master 1 requests.
    applyStimulus(3'b010, 3'b000, TRN_NONSEQ, BST_INCR4, 1'b1, "s4.beat1");
    applyStimulus(3'b010, 3'b000, TRN_SEQ, BST_INCR4, 1'b1, "s4.beat2");
    applyStimulus(3'b010, 3'b000, TRN_SEQ, BST_INCR4, 1'b0, "s4.wait1");
    compare("s4.grantWait1", HGRANT, 3'b001);
    applyStimulus(3'b010, 3'b000, TRN_SEQ, BST_INCR4, 1'b0, "s4.wait2");
    compare("s4.grantWait2", HGRANT, 3'b001);
    compare("s4.beatHold", {1'b0, dut.r_BeatCnt}, 3'd2);
    applyStimulus(3'b010, 3'b000, TRN_SEQ, BST_INCR4, 1'b1, "s4.beat3");
    compare("s4.grantSwitch", HGRANT, 3'b010);
    applyStimulus(3'b010, 3'b000, TRN_SEQ, BST_INCR4, 1'b1, "s4.beat4");
    compare("s4.ownerNext", {1'b0, HMASTER}, 3'd1);
    applyStimulus(3'b000, 3'b000, TRN_NONSEQ, BST_SINGLE, 1'b1, "s4.m1nonseq");
    applyStimulus(3'b000, 3'b000, TRN_IDLE, BST_SINGLE, 1'b1, "s4.idle");

    // Reset in the middle of an INCR4 burst discards the beat position.
    applyStimulus(3'b010, 3'b000, TRN_NONSEQ, BST_INCR4, 1'b1, "s6.beat1");
    applyStimulus(3'b010, 3'b000, TRN_SEQ, BST_INCR4, 1'b1, "s6.beat2");
    pulseReset("s6.reset");
    applyStimulus(3'b010, 3'b000, TRN_SEQ, BST_INCR4, 1'b1, "s6.afterReset");
    compare("s6.noStaleBeat", HGRANT, 3'b001);
    applyStimulus(3'b000, 3'b000, TRN_IDLE, BST_SINGLE, 1'b1, "s6.idle");

    // Three masters requesting continuously with single transfers.
    pulseReset("s5.reset");
`ifdef CAMERA_ARB_RR_EN
    rrExp = '{3'b010, 3'b100, 3'b001, 3'b010};
`else
    rrExp = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
    applyStimulus(3'b111, 3'b000, TRN_IDLE, BST_SINGLE, 1'b1, "s5.t0");
    compare("s5.order0", HGRANT, rrExp[0]);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(3'b111, 3'b000, TRN_NONSEQ, BST_SINGLE, 1'b1, $sformatf("s5.t%0d", i));
      compare($sformatf("s5.order%0d", i), HGRANT, rrExp[i]);
    end

    // Locked INCR from master 1 holds the bus against master 0.
    applyStimulus(3'b010, 3'b010, TRN_IDLE, BST_SINGLE, 1'b1, "s7.req");
    applyStimulus(3'b010, 3'b010, TRN_IDLE, BST_SINGLE, 1'b1, "s7.own");
    compare("s7.owner", {1'b0, HMASTER}, 3'd1);
    compare("s7.lockOwn", {2'b0, HMASTLOCK}, 3'd1);
    applyStimulus(3'b011, 3'b010, TRN_NONSEQ, BST_INCR, 1'b1, "s7.nonseq");
    compare("s7.grantHeld0", HGRANT, 3'b010);
    repeat (2) applyStimulus(3'b011, 3'b010, TRN_SEQ, BST_INCR, 1'b1, "s7.seq");
    compare("s7.grantHeld1", HGRANT, 3'b010);
    compare("s7.lockHeld", {2'b0, HMASTLOCK}, 3'd1);
    applyStimulus(3'b001, 3'b000, TRN_SEQ, BST_INCR, 1'b1, "s7.unlock");
    compare("s7.grantRelease", HGRANT, 3'b001);
    compare("s7.lockDrop", {2'b0, HMASTLOCK}, 3'd0);

    // Random traffic, including BUSY, wait states, odd HBURST codes and resets.
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 99) == 0) pulseReset($sformatf("rand%0d.reset", t));
      rReq  = N'($urandom);
      rLock = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      case ($urandom_range(0, 3))
        0:       rBurst = BST_SINGLE;
        1:       rBurst = BST_INCR;
        2:       rBurst = BST_INCR4;
        default: rBurst = 3'($urandom);
      endcase
      applyStimulus(rReq, rLock, 2'($urandom), rBurst, $urandom_range(0, 3) != 0,
                    $sformatf("rand%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
